// File: rtl/mux_pkg.sv
// Shared types for the two-input round-robin stream merge.
package mux_pkg;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_t;

    localparam int DEFAULT_N = 4;

endpackage

// File: rtl/mux_2x1.sv
// N-bit 2-to-1 multiplexer used as the datapath steer.
module mux_2x1 #(
    parameter int N = 4
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic         sel,
    output logic [N-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux2_rr_stream.sv
// Round-robin merge of two valid/ready producers into one registered
// output stage; the arbiter's grant drives the shared 2-to-1 mux select.
module mux2_rr_stream
    import mux_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d0,
    input  logic         v0,
    output logic         r0,
    input  logic [N-1:0] d1,
    input  logic         v1,
    output logic         r1,
    output logic [N-1:0] y,
    output logic         y_valid,
    input  logic         y_ready,
    output logic         y_src
);

    pri_t         pri_q, pri_d;
    logic         sel_q, sel_d;
    logic [N-1:0] y_q, y_d;
    logic         y_valid_q, y_valid_d;
    logic         y_src_q, y_src_d;
    logic [N-1:0] mux_y;
    logic         ld;

    mux_2x1 #(.N(N)) u_mux (
        .d0  (d0),
        .d1  (d1),
        .sel (sel_d),
        .y   (mux_y)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        sel_d     = sel_q;
        pri_d     = pri_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_src_d   = y_src_q;

        // With no valid input the select keeps its last value so the
        // steered bus stays quiet while idle.
        if (v0 && !v1) begin
            sel_d = 1'b0;
        end else if (!v0 && v1) begin
            sel_d = 1'b1;
        end else if (v0 && v1) begin
            sel_d = (pri_q == PRI1);
        end

        ld = !rst && (!y_valid_q || y_ready) && (v0 || v1);
        r0 = ld && !sel_d;
        r1 = ld &&  sel_d;

        if (ld) begin
            pri_d     = sel_d ? PRI0 : PRI1;
            y_d       = mux_y;
            y_src_d   = sel_d;
            y_valid_d = 1'b1;
        end else if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q     <= PRI0;
            sel_q     <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_src_q   <= 1'b0;
        end else begin
            pri_q     <= pri_d;
            sel_q     <= sel_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_src_q   <= y_src_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_src   = y_src_q;

endmodule

// File: tb/tb_mux2_rr_stream.sv
// Directed bench for mux2_rr_stream: reset, single source, fairness,
// backpressure, drain and reset during a stall.
module tb_mux2_rr_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d0, d1;
    logic       v0, v1, r0, r1;
    logic [3:0] y;
    logic       y_valid, y_ready, y_src;

    int checks   = 0;
    int failures = 0;

    mux2_rr_stream #(.N(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .d0      (d0),
        .v0      (v0),
        .r0      (r0),
        .d1      (d1),
        .v1      (v1),
        .r1      (r1),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_src   (y_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 4'b0001; d1 = 4'b0010; y_ready = 1'b1;
        tick();
        tick();
        check("rst_r0", 32'(r0), 0);
        check("rst_r1", 32'(r1), 0);
        check("rst_y", 32'(y), 0);
        check("rst_y_valid", 32'(y_valid), 0);
        check("rst_y_src", 32'(y_src), 0);

        // Release: both pending, channel 0 wins first.
        rst = 1'b0;
        #1;
        check("first_r0", 32'(r0), 1);
        check("first_r1", 32'(r1), 0);
        tick();
        check("first_y", 32'(y), 4'b0001);
        check("first_y_valid", 32'(y_valid), 1);
        check("first_y_src", 32'(y_src), 0);
        check("after_first_r1", 32'(r1), 1);
        check("after_first_r0", 32'(r0), 0);

        // Single source on channel 1.
        v0 = 1'b0; v1 = 1'b1; d1 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("single_y", 32'(y), 4'b1010);
            check("single_y_src", 32'(y_src), 1);
            check("single_r1", 32'(r1), 1);
            check("single_r0", 32'(r0), 0);
        end

        // Contention: priority is PRI0 after the channel-1 transfers.
        v0 = 1'b1; v1 = 1'b1; d0 = 4'b1111; d1 = 4'b0000;
        #1;
        check("cont_start_r0", 32'(r0), 1);
        for (int i = 0; i < 6; i++) begin
            check("cont_not_both", 32'(r0 & r1), 0);
            tick();
            check("cont_y", 32'(y), (i % 2 == 0) ? 32'hF : 32'h0);
            check("cont_y_src", 32'(y_src), (i % 2 == 0) ? 0 : 1);
        end

        // Backpressure: load 0001 from channel 0, leaving PRI1.
        v0 = 1'b1; v1 = 1'b0; d0 = 4'b0001; d1 = 4'b0010;
        tick();
        check("bp_fill_y", 32'(y), 4'b0001);
        y_ready = 1'b0; v1 = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_r0", 32'(r0), 0);
            check("bp_r1", 32'(r1), 0);
            tick();
            check("bp_y", 32'(y), 4'b0001);
            check("bp_y_valid", 32'(y_valid), 1);
        end
        y_ready = 1'b1;
        #1;
        check("bp_release_r1", 32'(r1), 1);
        check("bp_release_r0", 32'(r0), 0);
        tick();
        check("bp_reload_y", 32'(y), 4'b0010);
        check("bp_reload_y_src", 32'(y_src), 1);
        check("bp_reload_y_valid", 32'(y_valid), 1);

        // Drain to empty.
        v0 = 1'b0; v1 = 1'b0;
        #1;
        check("drain_r0", 32'(r0), 0);
        check("drain_r1", 32'(r1), 0);
        tick();
        check("drain_y_valid", 32'(y_valid), 0);
        check("drain_y_hold", 32'(y), 4'b0010);
        check("drain_y_src_hold", 32'(y_src), 1);
        tick();
        check("idle_y_valid", 32'(y_valid), 0);
        check("idle_y_hold", 32'(y), 4'b0010);

        // Reset during a stall: load from channel 0 (leaves PRI1), then stall.
        v0 = 1'b1; d0 = 4'b0101; d1 = 4'b0110;
        tick();
        check("rs_load_y", 32'(y), 4'b0101);
        check("rs_load_y_valid", 32'(y_valid), 1);
        y_ready = 1'b0; v1 = 1'b1;
        tick();
        check("rs_stall_y", 32'(y), 4'b0101);
        y_ready = 1'b1; rst = 1'b1;
        #1;
        check("rs_rst_r0", 32'(r0), 0);
        check("rs_rst_r1", 32'(r1), 0);
        tick();
        check("rs_y", 32'(y), 0);
        check("rs_y_valid", 32'(y_valid), 0);
        check("rs_y_src", 32'(y_src), 0);
        rst = 1'b0;
        #1;
        check("rs_after_r0", 32'(r0), 1);
        check("rs_after_r1", 32'(r1), 0);
        tick();
        check("rs_after_y", 32'(y), 4'b0101);
        check("rs_after_y_src", 32'(y_src), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
